// File: rtl/types_pkg.sv
// Shared types for the load/store path.
//   DATA_BUS     : width of every data path (32).
//   byte_format  : access size, BYTE / HALF / WORD.
//   lsu_state_t  : load_store_unit FSM states (IDLE, ACC0, ACC1, RESP).
//   is_misaligned: true when an access of the given size crosses a word boundary.
package types_pkg;

  localparam int unsigned DATA_BUS = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } byte_format;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAcc0 = 2'b01,
    StAcc1 = 2'b10,
    StResp = 2'b11
  } lsu_state_t;

  function automatic logic is_misaligned(byte_format size, logic [1:0] off);
    logic mis;
    case (size)
      HALF:    mis = (off == 2'd3);
      WORD:    mis = (off != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
// Byte enables and store data are produced over a two-word window: the low word
// is the first (or only) access, the high word is the spill into the next word
// of a split access. Loads take the same two-word window, shift the addressed
// bytes down to lane 0 and zero- or sign-extend by size.
// Ports:
//   size_i   access size          off_i    byte offset within the word
//   uns_i    zero-extend loads    wdata_i  right-aligned store data
//   rdata_i  {second word, first word} of read data
//   be_o     8 lane enables (low 4 = first access, high 4 = second access)
//   wdata_o  lane-shifted store data over the two-word window
//   rdata_o  extracted, extended load data
module lsu_lane_align
  import types_pkg::*;
(
  input  byte_format                size_i,
  input  logic [1:0]                off_i,
  input  logic                      uns_i,
  input  logic [DATA_BUS-1:0]       wdata_i,
  input  logic [2*DATA_BUS-1:0]     rdata_i,
  output logic [7:0]                be_o,
  output logic [2*DATA_BUS-1:0]     wdata_o,
  output logic [DATA_BUS-1:0]       rdata_o
);

  logic [3:0]            base_be;
  logic [4:0]            shamt;
  logic [2*DATA_BUS-1:0] rshift;

  always_comb begin
    case (size_i)
      HALF:    base_be = 4'b0011;
      WORD:    base_be = 4'b1111;
      default: base_be = 4'b0001;
    endcase

    shamt   = {off_i, 3'b000};
    be_o    = {4'b0000, base_be} << off_i;
    wdata_o = {{DATA_BUS{1'b0}}, wdata_i} << shamt;
    rshift  = rdata_i >> shamt;

    case (size_i)
      BYTE:    rdata_o = {{(DATA_BUS-8){~uns_i & rshift[7]}}, rshift[7:0]};
      HALF:    rdata_o = {{(DATA_BUS-16){~uns_i & rshift[15]}}, rshift[15:0]};
      default: rdata_o = rshift[DATA_BUS-1:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU access at a time and drives a word-addressed,
// byte-enabled data memory with one-cycle read latency.
// Build option: LSU_MISALIGN_EN -- when defined, misaligned accesses are split
// into two word accesses (ACC0, ACC1); when undefined they perform no memory
// write and respond with misalign_err = 1.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data (0 for stores), held until next response
//   misalign_err          error flag, qualified by resp_valid
//   mem_we, mem_be, mem_addr, mem_wdata, mem_rdata        data memory port
module load_store_unit
  import types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  byte_format          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_BUS-1:0] req_wdata,
  output logic                resp_valid,
  output logic [DATA_BUS-1:0] resp_rdata,
  output logic                misalign_err,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_BUS-1:0] mem_wdata,
  input  logic [DATA_BUS-1:0] mem_rdata
);

  lsu_state_t state_q, state_d;

  logic                we_q;
  logic                uns_q;
  byte_format          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_BUS-1:0] wdata_q;
  logic [DATA_BUS-1:0] lo_q;     // read data of the first half of a split load
  logic                resp_valid_q;
  logic                err_q;
  logic [DATA_BUS-1:0] rdata_q;

  logic                  mis;
  logic                  split;
  logic                  bad;
  logic [ADDR_W-1:0]     word_addr;
  logic [7:0]            lane_be;
  logic [2*DATA_BUS-1:0] lane_wdata;
  logic [2*DATA_BUS-1:0] rd_window;
  logic [DATA_BUS-1:0]   load_data;

  assign mis = is_misaligned(size_q, addr_q[1:0]);

`ifdef LSU_MISALIGN_EN
  assign split = mis;
  assign bad   = 1'b0;
`else
  assign split = 1'b0;
  assign bad   = mis;
`endif

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // During RESP, mem_rdata carries the last access; a split load pairs it with
  // the first word captured in ACC1.
  assign rd_window = split ? {mem_rdata, lo_q} : {{DATA_BUS{1'b0}}, mem_rdata};

  lsu_lane_align u_lane_align (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .rdata_i (rd_window),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == StAcc1) begin
        lo_q <= mem_rdata;
      end
      resp_valid_q <= (state_q == StResp);
      err_q        <= (state_q == StResp) && bad;
      if (state_q == StResp) begin
        rdata_q <= (we_q || bad) ? '0 : load_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      StIdle: begin
        if (req_valid) state_d = StAcc0;
      end
      StAcc0: begin
        state_d  = split ? StAcc1 : StResp;
        mem_addr = word_addr;
        if (!bad) begin
          mem_we    = we_q;
          mem_be    = lane_be[3:0];
          mem_wdata = lane_wdata[DATA_BUS-1:0];
        end
      end
      StAcc1: begin
        state_d   = StResp;
        mem_addr  = word_addr + ADDR_W'(4);
        mem_we    = we_q;
        mem_be    = lane_be[7:4];
        mem_wdata = lane_wdata[2*DATA_BUS-1:DATA_BUS];
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign req_ready    = (state_q == StIdle);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = rdata_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import types_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  byte_format  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 words indexed by addr[9:2], one-cycle read latency.
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  // Observations of the last request, index k = k-th falling edge after accept.
  logic [3:0]  obs_be   [0:8];
  logic [31:0] obs_addr [0:8];
  logic [31:0] obs_wd   [0:8];
  int          lat;
  int          we_cyc;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        after_valid;
  logic        after_ready;

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic we, input byte_format sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Issues one request and records outputs until resp_valid (bounded).
  task automatic run_req(input logic we, input byte_format sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic got;
    drive_req(we, sz, uns, addr, wd);
    lat = 0; we_cyc = 0; got = 1'b0;
    obs_rdata = 32'hx; obs_err = 1'bx;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      obs_be[k] = mem_be; obs_addr[k] = mem_addr; obs_wd[k] = mem_wdata;
      if (mem_we) we_cyc++;
      if (resp_valid) begin
        got = 1'b1; lat = k; obs_rdata = resp_rdata; obs_err = misalign_err;
      end
    end
    @(negedge clk);
    after_valid = resp_valid;
    after_ready = req_ready;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", misalign_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL reset_mem_be got %b want 0000", mem_be); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_load_word;
    preload(8'd64, 32'hDEADBEEF);
    run_req(1'b0, WORD, 1'b0, 32'h100, 32'h0);
    checks++; if (obs_be[1] !== 4'b1111) begin errors++; $display("FAIL lw_be got %b want 1111", obs_be[1]); end
    checks++; if (obs_addr[1] !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", obs_addr[1]); end
    // Aligned: resp_valid seen at the 3rd falling edge after accept.
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", obs_rdata); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b want 0", obs_err); end
    checks++; if (we_cyc !== 0) begin errors++; $display("FAIL lw_no_write got %0d want 0", we_cyc); end
    checks++; if (after_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse got %b want 0", after_valid); end
    checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata_hold got %h want deadbeef", resp_rdata); end
  endtask

  task automatic test_load_byte;
    preload(8'd64, 32'h80FFFFFF);
    run_req(1'b0, BYTE, 1'b0, 32'h103, 32'h0);
    checks++; if (obs_be[1] !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", obs_be[1]); end
    checks++; if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h want ffffff80", obs_rdata); end
    run_req(1'b0, BYTE, 1'b1, 32'h103, 32'h0);
    checks++; if (obs_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", obs_rdata); end
    run_req(1'b0, HALF, 1'b0, 32'h102, 32'h0);
    checks++; if (obs_be[1] !== 4'b1100) begin errors++; $display("FAIL lh_be got %b want 1100", obs_be[1]); end
    checks++; if (obs_rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_signed got %h want ffff80ff", obs_rdata); end
  endtask

  task automatic test_store;
    run_req(1'b1, HALF, 1'b0, 32'h102, 32'h00001234);
    checks++; if (obs_be[1] !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", obs_be[1]); end
    checks++; if (obs_wd[1] !== 32'h12340000) begin errors++; $display("FAIL sh_wdata got %h want 12340000", obs_wd[1]); end
    checks++; if (we_cyc !== 1) begin errors++; $display("FAIL sh_we_cycles got %0d want 1", we_cyc); end
    checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL sh_rdata got %h want 0", obs_rdata); end
    run_req(1'b1, BYTE, 1'b0, 32'h101, 32'h000000AB);
    checks++; if (obs_be[1] !== 4'b0010) begin errors++; $display("FAIL sb_be got %b want 0010", obs_be[1]); end
    checks++; if (obs_wd[1] !== 32'h0000AB00) begin errors++; $display("FAIL sb_wdata got %h want 0000ab00", obs_wd[1]); end
  endtask

  task automatic test_back_to_back;
    // Memory word 0x100 is now 0x1234ABFF after the two stores.
    run_req(1'b0, WORD, 1'b0, 32'h100, 32'h0);
    checks++; if (obs_rdata !== 32'h1234ABFF) begin errors++; $display("FAIL b2b_word got %h want 1234abff", obs_rdata); end
    checks++; if (after_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", after_ready); end
    run_req(1'b0, HALF, 1'b1, 32'h100, 32'h0);
    checks++; if (obs_rdata !== 32'h0000ABFF) begin errors++; $display("FAIL b2b_lhu got %h want 0000abff", obs_rdata); end
    run_req(1'b0, HALF, 1'b0, 32'h100, 32'h0);
    checks++; if (obs_rdata !== 32'hFFFFABFF) begin errors++; $display("FAIL b2b_lh got %h want ffffabff", obs_rdata); end
  endtask

`ifdef LSU_MISALIGN_EN
  task automatic test_split_load;
    preload(8'd64, 32'h44332211);
    preload(8'd65, 32'h88776655);
    run_req(1'b0, WORD, 1'b0, 32'h101, 32'h0);
    checks++; if (obs_be[1] !== 4'b1110) begin errors++; $display("FAIL split_be0 got %b want 1110", obs_be[1]); end
    checks++; if (obs_be[2] !== 4'b0001) begin errors++; $display("FAIL split_be1 got %b want 0001", obs_be[2]); end
    checks++; if (obs_addr[2] !== 32'h104) begin errors++; $display("FAIL split_addr1 got %h want 104", obs_addr[2]); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL split_latency got %0d want 4", lat); end
    checks++; if (obs_rdata !== 32'h55443322) begin errors++; $display("FAIL split_rdata got %h want 55443322", obs_rdata); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL split_err got %b want 0", obs_err); end
  endtask

  task automatic test_wrap_reset;
    int seen;
    run_req(1'b1, WORD, 1'b0, 32'hFFFFFFFE, 32'h11223344);
    checks++; if (obs_addr[1] !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr0 got %h want fffffffc", obs_addr[1]); end
    checks++; if (obs_addr[2] !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h want 0", obs_addr[2]); end
    checks++; if (obs_wd[1] !== 32'h33440000) begin errors++; $display("FAIL wrap_wd0 got %h want 33440000", obs_wd[1]); end
    checks++; if (obs_wd[2] !== 32'h00001122) begin errors++; $display("FAIL wrap_wd1 got %h want 00001122", obs_wd[2]); end
    checks++; if (we_cyc !== 2) begin errors++; $display("FAIL wrap_we_cycles got %0d want 2", we_cyc); end
    // Same store again, reset asserted during ACC1.
    drive_req(1'b1, WORD, 1'b0, 32'hFFFFFFFE, 32'h11223344);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_acc1_we got %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_async_we got %b want 0", mem_we); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL rst_async_be got %b want 0000", mem_be); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_resp got %0d want 0", seen); end
  endtask
`else
  task automatic test_misalign_err;
    preload(8'd64, 32'h44332211);
    preload(8'd65, 32'h88776655);
    run_req(1'b0, WORD, 1'b0, 32'h101, 32'h0);
    checks++; if (obs_be[1] !== 4'b0000) begin errors++; $display("FAIL mis_be got %b want 0000", obs_be[1]); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL mis_latency got %0d want 3", lat); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", obs_err); end
    checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h want 0", obs_rdata); end
    run_req(1'b1, HALF, 1'b0, 32'h103, 32'h0000BEEF);
    checks++; if (we_cyc !== 0) begin errors++; $display("FAIL mis_store_we got %0d want 0", we_cyc); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL mis_store_err got %b want 1", obs_err); end
    run_req(1'b0, WORD, 1'b0, 32'h100, 32'h0);
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL mis_clear_err got %b want 0", obs_err); end
    checks++; if (obs_rdata !== 32'h44332211) begin errors++; $display("FAIL mis_untouched got %h want 44332211", obs_rdata); end
  endtask

  task automatic test_reset_mid;
    int seen;
    preload(8'd128, 32'h0);
    drive_req(1'b1, WORD, 1'b0, 32'h200, 32'hCAFEF00D);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_acc0_we got %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_async_we got %b want 0", mem_we); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL rst_async_be got %b want 0000", mem_be); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_resp got %0d want 0", seen); end
    run_req(1'b0, WORD, 1'b0, 32'h200, 32'h0);
    checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL rst_discard got %h want 0", obs_rdata); end
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = BYTE; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    pl_en = 1'b0; pl_idx = 8'h0; pl_data = 32'h0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store();
    test_back_to_back();
`ifdef LSU_MISALIGN_EN
    test_split_load();
    test_wrap_reset();
`else
    test_misalign_err();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The parameter list SHALL be: ADDR_W, default 32, byte-address width; all data paths SHALL be DATA_BUS (32 bit).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge;
  rst_n  in  1  reset, asynchronous, active-low;
  req_valid  in  1  CPU access request;
  req_ready  out  1  unit can accept a request;
  req_we  in  1  1 = store, 0 = load;
  req_size  in  byte_format  BYTE, HALF or WORD;
  req_unsigned  in  1  zero-extend loads;
  req_addr  in  ADDR_W  byte address;
  req_wdata  in  32  store data, right-aligned;
  resp_valid  out  1  one-cycle completion pulse;
  resp_rdata  out  32  extended load data;
  misalign_err  out  1  error flag, qualified by resp_valid;
  mem_we  out  1  data-memory write enable;
  mem_be  out  4  byte-lane enables;
  mem_addr  out  ADDR_W  word address, low two bits 0;
  mem_wdata  out  32  lane-shifted store data;
  mem_rdata  in  32  read data, valid one cycle after mem_addr.
REQ-003 Clock and reset SHALL be exactly as decided: one clock clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 The FSM SHALL use the states IDLE, ACC0, ACC1 and RESP; req_ready SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted when req_valid and req_ready are both 1 at a rising edge; all request fields SHALL be latched at that edge.
REQ-006 The transitions SHALL be: IDLE to ACC0 on accept; ACC0 to ACC1 if the access is split, otherwise to RESP; ACC1 to RESP; RESP to IDLE.
REQ-007 Latency: accept at edge T; an aligned access SHALL pulse resp_valid in the cycle after edge T+2; a split access SHALL pulse it one cycle later.
REQ-008 The lane offset SHALL be off = addr[1:0]; BYTE SHALL be always aligned; HALF SHALL be misaligned when off = 3; WORD SHALL be misaligned when off != 0.
REQ-009 Aligned lanes: BYTE SHALL set be = 1 << off; HALF SHALL set be = 0011 << off; WORD SHALL set be = 1111; mem_wdata SHALL be req_wdata shifted left by 8*off.
REQ-010 Split, ACC0: mem_addr SHALL be the word address and be SHALL cover lanes off..3.
REQ-011 Split, ACC1: mem_addr SHALL be the word address + 4, wrapping at 2^ADDR_W, and be SHALL cover the remaining low lanes.
REQ-012 mem_we SHALL equal the latched req_we in ACC0 and ACC1 and SHALL be 0 in every other state; mem_be SHALL be 0000 outside ACC0 and ACC1.
REQ-013 Loads: mem_rdata SHALL be captured one cycle after each access phase, assembled in byte order, then zero- or sign-extended to 32 bits.
REQ-014 resp_rdata SHALL be registered and held stable until the next response; stores SHALL return resp_rdata = 0.
REQ-015 There is no response backpressure: resp_valid SHALL be a single-cycle pulse.

Reset
REQ-016 While rst_n = 0, the unit SHALL be in IDLE, with req_ready = 1 after release, and with resp_valid, misalign_err, mem_we, mem_be, mem_addr, mem_wdata and resp_rdata all 0.
REQ-017 A reset asserted mid-operation SHALL drop mem_we immediately (asynchronously), discard the access, and produce no response.

Configuration
REQ-018 With the macro LSU_MISALIGN_EN defined, misaligned accesses SHALL be split per REQ-010 and REQ-011, and misalign_err SHALL be constant 0.
REQ-019 Without LSU_MISALIGN_EN, a misaligned access SHALL go IDLE to ACC0 to RESP with mem_we = 0 and mem_be = 0000, and SHALL respond with misalign_err = 1 and resp_rdata = 0; ACC1 SHALL be unreachable.

Structure
REQ-020 byte_format and DATA_BUS SHALL come from types_pkg; the lsu_state_t enum SHALL be added to types_pkg.
REQ-021 One combinational sub-module, lsu_lane_align, SHALL compute be, shifted write data and load extraction/extension; the FSM SHALL stay in load_store_unit.

Verification
REQ-022 Scenario: load, WORD, addr 0x100, memory holds 0xDEADBEEF -> be = 1111, resp_valid two cycles after accept, resp_rdata = 0xDEADBEEF.
REQ-023 Scenario: load, BYTE, signed, addr 0x103, memory word 0x80FFFFFF -> be = 1000, resp_rdata = 0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-024 Scenario: store, HALF, addr 0x102, wdata 0x1234 -> mem_be = 1100, mem_wdata = 0x12340000, mem_we = 1 for exactly one cycle.
REQ-025 Scenario: LSU_MISALIGN_EN defined; load, WORD, addr 0x101, words at 0x100 = 0x44332211 and 0x104 = 0x88776655 -> two accesses with be 1110 then 0001, resp_rdata = 0x55443322.
REQ-026 Scenario: macro undefined, same request as REQ-025 -> no write and mem_be = 0000, then resp_valid with misalign_err = 1.
REQ-027 Scenario: wrap and reset -> a split store at 0xFFFFFFFE sends its second access to 0x00000000; asserting rst_n = 0 during ACC1 drops mem_we at once and produces no resp_valid.
